// File: rtl/pc_gen_if.sv
// rtl/pc_gen_if.sv - fetch-address handshake between the PC generator and IF.
interface pc_gen_if #(
  parameter int ADDR_W = 32
);
  logic [ADDR_W-1:0] pc2if_addr_o;
  logic              pc2if_valid_o;
  logic              if2pc_ready_i;

  modport master (output pc2if_addr_o, output pc2if_valid_o, input  if2pc_ready_i);
  modport slave  (input  pc2if_addr_o, input  pc2if_valid_o, output if2pc_ready_i);
endinterface

// File: rtl/pc_gen.sv
// rtl/pc_gen.sv - program-counter generator with trap/jump redirect, halt/resume and fetch counter.
// Optional feature macro: PC_MISALIGN_TRAP_EN (misaligned jump targets redirect to the trap vector).
module pc_gen #(
  parameter int          ADDR_W     = 32,
  parameter logic [31:0] RESET_VEC  = 32'h0,
  parameter int          INC        = 4,
  parameter int          ALIGN_BITS = 2,
  parameter int          CNT_W      = 32
) (
  input  logic              clk,
  input  logic              rest,
  pc_gen_if.master          pc2if,
  input  logic              cu2pc_jump_en_i,
  input  logic [ADDR_W-1:0] ex2pc_jump_addr_i,
  input  logic              cu2pc_trap_en_i,
  input  logic [ADDR_W-1:0] cu2pc_trap_vec_i,
  input  logic              cu2pc_halt_i,
  output logic              pc_halted_o,
  output logic              pc_misalign_o,
  output logic [CNT_W-1:0]  fetch_cnt_o
);

  typedef enum logic [1:0] {
    BOOT = 2'd0,
    RUN  = 2'd1,
    HALT = 2'd2
  } state_t;

  localparam logic [ADDR_W-1:0] RESET_PC   = ADDR_W'(RESET_VEC);
  localparam logic [ADDR_W-1:0] ALIGN_MASK = ~((ADDR_W'(1) << ALIGN_BITS) - ADDR_W'(1));

  state_t            r_state;
  logic [ADDR_W-1:0] r_pc;
  logic              r_valid;
  logic              r_halted;
  logic [CNT_W-1:0]  r_cnt;

  logic              w_fetch;
  logic              w_redirect_ok;
  logic [ADDR_W-1:0] w_trap_pc;
  logic [ADDR_W-1:0] w_jump_pc;

  assign w_fetch       = (r_state == RUN) && r_valid && pc2if.if2pc_ready_i;
  assign w_redirect_ok = (r_state != BOOT);
  assign w_trap_pc     = cu2pc_trap_vec_i & ALIGN_MASK;
  assign w_jump_pc     = ex2pc_jump_addr_i & ALIGN_MASK;

`ifdef PC_MISALIGN_TRAP_EN
  logic r_misalign;
  logic w_jump_misaligned;

  assign w_jump_misaligned = |(ex2pc_jump_addr_i & ~ALIGN_MASK);
  assign pc_misalign_o     = r_misalign;
`else
  assign pc_misalign_o = 1'b0;
`endif

  always_ff @(posedge clk or negedge rest) begin
    if (!rest) begin
      r_state  <= BOOT;
      r_pc     <= RESET_PC;
      r_valid  <= 1'b0;
      r_halted <= 1'b0;
      r_cnt    <= '0;
`ifdef PC_MISALIGN_TRAP_EN
      r_misalign <= 1'b0;
`endif
    end else begin
`ifdef PC_MISALIGN_TRAP_EN
      r_misalign <= 1'b0;
`endif
      case (r_state)
        BOOT: begin
          r_state <= RUN;
          r_valid <= 1'b1;
        end
        RUN: begin
          if (cu2pc_halt_i) begin
            r_state  <= HALT;
            r_valid  <= 1'b0;
            r_halted <= 1'b1;
          end
        end
        HALT: begin
          if (!cu2pc_halt_i) begin
            r_state  <= RUN;
            r_valid  <= 1'b1;
            r_halted <= 1'b0;
          end
        end
        default: begin
          r_state  <= BOOT;
          r_valid  <= 1'b0;
          r_halted <= 1'b0;
        end
      endcase

      // An address accepted in the same cycle as a redirect still counts.
      if (w_fetch) begin
        r_cnt <= r_cnt + CNT_W'(1);
      end

      if (w_redirect_ok && cu2pc_trap_en_i) begin
        r_pc <= w_trap_pc;
      end else if (w_redirect_ok && cu2pc_jump_en_i) begin
`ifdef PC_MISALIGN_TRAP_EN
        if (w_jump_misaligned) begin
          r_pc       <= w_trap_pc;
          r_misalign <= 1'b1;
        end else begin
          r_pc <= w_jump_pc;
        end
`else
        r_pc <= w_jump_pc;
`endif
      end else if (w_fetch) begin
        r_pc <= r_pc + ADDR_W'(INC);
      end
    end
  end

  assign pc2if.pc2if_addr_o  = r_pc;
  assign pc2if.pc2if_valid_o = r_valid;
  assign pc_halted_o         = r_halted;
  assign fetch_cnt_o         = r_cnt;

endmodule

// File: tb/tb_pc_gen.sv
// tb/tb_pc_gen.sv - table-driven directed bench for pc_gen (honours PC_MISALIGN_TRAP_EN if defined).
module tb_pc_gen;

  logic        clk;
  logic        rest;
  logic        jump_en;
  logic [31:0] jump_addr;
  logic        trap_en;
  logic [31:0] trap_vec;
  logic        halt;
  logic        halted;
  logic        misalign;
  logic [31:0] cnt;

  pc_gen_if #(.ADDR_W(32)) bus ();

  pc_gen dut (
    .clk               (clk),
    .rest              (rest),
    .pc2if             (bus.master),
    .cu2pc_jump_en_i   (jump_en),
    .ex2pc_jump_addr_i (jump_addr),
    .cu2pc_trap_en_i   (trap_en),
    .cu2pc_trap_vec_i  (trap_vec),
    .cu2pc_halt_i      (halt),
    .pc_halted_o       (halted),
    .pc_misalign_o     (misalign),
    .fetch_cnt_o       (cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        ready;
    logic        jmp;
    logic [31:0] jaddr;
    logic        trp;
    logic [31:0] tvec;
    logic        hlt;
    logic [31:0] e_addr;
    logic        e_valid;
    logic        e_halted;
    logic        e_mis;
    logic [31:0] e_cnt;
  } vec_t;

  vec_t vq[$];
  int   n_vec;
  int   n_err;

`ifdef PC_MISALIGN_TRAP_EN
  localparam bit MIS_ON = 1'b1;
`else
  localparam bit MIS_ON = 1'b0;
`endif

  task automatic add(input logic r, input logic j, input logic [31:0] ja, input logic t,
                     input logic [31:0] tv, input logic h, input logic [31:0] ea, input logic ev,
                     input logic eh, input logic em, input logic [31:0] ec);
    vec_t v;
    v.ready = r; v.jmp = j; v.jaddr = ja; v.trp = t; v.tvec = tv; v.hlt = h;
    v.e_addr = ea; v.e_valid = ev; v.e_halted = eh; v.e_mis = em; v.e_cnt = ec;
    vq.push_back(v);
  endtask

  task automatic check(input string name, input logic [31:0] ea, input logic ev,
                       input logic eh, input logic em, input logic [31:0] ec);
    n_vec++;
    if (bus.pc2if_addr_o !== ea || bus.pc2if_valid_o !== ev || halted !== eh ||
        misalign !== em || cnt !== ec) begin
      n_err++;
      $display("FAIL %s: got addr=%h valid=%b halted=%b mis=%b cnt=%0d, want addr=%h valid=%b halted=%b mis=%b cnt=%0d",
               name, bus.pc2if_addr_o, bus.pc2if_valid_o, halted, misalign, cnt,
               ea, ev, eh, em, ec);
    end
  endtask

  task automatic drive(input logic r, input logic j, input logic [31:0] ja,
                       input logic t, input logic [31:0] tv, input logic h);
    bus.if2pc_ready_i = r; jump_en = j; jump_addr = ja; trap_en = t; trap_vec = tv; halt = h;
  endtask

  initial begin
    #20000;
    $display("FAIL watchdog: simulation time limit reached, want completion");
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err + 1);
    $fatal(1);
  end

  initial begin
    n_vec = 0;
    n_err = 0;
    rest  = 1'b0;
    drive(1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);

    // Stimulus table: inputs held for one edge, outputs expected after that edge.
    add(1, 0, 0, 0, 0, 0, 32'h0,   1, 0, 0, 0);   // BOOT -> RUN
    add(1, 0, 0, 0, 0, 0, 32'h4,   1, 0, 0, 1);
    add(1, 0, 0, 0, 0, 0, 32'h8,   1, 0, 0, 2);
    add(1, 0, 0, 0, 0, 0, 32'hC,   1, 0, 0, 3);
    add(1, 0, 0, 0, 0, 0, 32'h10,  1, 0, 0, 4);
    add(0, 0, 0, 0, 0, 0, 32'h10,  1, 0, 0, 4);   // stall x3
    add(0, 0, 0, 0, 0, 0, 32'h10,  1, 0, 0, 4);
    add(0, 0, 0, 0, 0, 0, 32'h10,  1, 0, 0, 4);
    add(1, 0, 0, 0, 0, 0, 32'h14,  1, 0, 0, 5);
    add(1, 1, 32'h200, 1, 32'h80, 0, 32'h80, 1, 0, 0, 6);  // trap beats jump, accept counted
    add(0, 1, 32'h200, 0, 0, 0, 32'h200, 1, 0, 0, 6);      // jump with ready=0
    add(1, 0, 0, 0, 0, 0, 32'h204, 1, 0, 0, 7);
    add(0, 1, 32'h40, 0, 0, 0, 32'h40, 1, 0, 0, 7);
    add(0, 0, 0, 0, 0, 1, 32'h40,  0, 1, 0, 7);   // halt at 0x40
    add(1, 1, 32'h300, 0, 0, 1, 32'h300, 0, 1, 0, 7);      // jump while halted
    add(1, 0, 0, 0, 0, 0, 32'h300, 1, 0, 0, 7);   // resume
    add(1, 0, 0, 0, 0, 0, 32'h304, 1, 0, 0, 8);
    add(1, 0, 0, 0, 0, 0, 32'h308, 1, 0, 0, 9);
    add(0, 0, 0, 1, 32'h500, 1, 32'h500, 0, 1, 0, 9);      // trap + halt together
    add(0, 0, 0, 0, 0, 0, 32'h500, 1, 0, 0, 9);
    add(0, 1, 32'hFFFF_FFFC, 0, 0, 0, 32'hFFFF_FFFC, 1, 0, 0, 9);
    add(1, 0, 0, 0, 0, 0, 32'h0,   1, 0, 0, 10);  // PC wraps
    add(1, 0, 0, 0, 0, 0, 32'h4,   1, 0, 0, 11);
    add(0, 0, 0, 1, 32'h703, 0, 32'h700, 1, 0, 0, 11);     // trap vector aligned
    add(0, 1, 32'h102, 0, 32'h600, 0, MIS_ON ? 32'h600 : 32'h100, 1, 0, MIS_ON, 11);
    add(0, 0, 0, 0, 32'h600, 0, MIS_ON ? 32'h600 : 32'h100, 1, 0, 0, 11);
    add(0, 1, 32'h103, 1, 32'h800, 0, 32'h800, 1, 0, 0, 11);

    repeat (2) @(posedge clk);
    #1;
    check("reset_state", 32'h0, 1'b0, 1'b0, 1'b0, 32'd0);
    rest = 1'b1;
    #1;
    check("boot_before_edge", 32'h0, 1'b0, 1'b0, 1'b0, 32'd0);

    for (int i = 0; i < vq.size(); i++) begin
      drive(vq[i].ready, vq[i].jmp, vq[i].jaddr, vq[i].trp, vq[i].tvec, vq[i].hlt);
      @(posedge clk);
      #1;
      check($sformatf("vec%0d", i), vq[i].e_addr, vq[i].e_valid, vq[i].e_halted,
            vq[i].e_mis, vq[i].e_cnt);
    end

    // Async reset mid-stall, away from any clock edge.
    drive(1'b0, 1'b1, 32'h900, 1'b0, 32'h0, 1'b0);
    @(posedge clk);
    #3;
    rest = 1'b0;
    #1;
    check("async_reset", 32'h0, 1'b0, 1'b0, 1'b0, 32'd0);
    @(posedge clk);
    #1;
    check("reset_held", 32'h0, 1'b0, 1'b0, 1'b0, 32'd0);

    // Redirect requested during BOOT is ignored.
    rest = 1'b1;
    drive(1'b1, 1'b0, 32'h0, 1'b1, 32'hA00, 1'b0);
    @(posedge clk);
    #1;
    check("boot_ignores_trap", 32'h0, 1'b1, 1'b0, 1'b0, 32'd0);
    drive(1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
    @(posedge clk);
    #1;
    check("post_reset_fetch", 32'h4, 1'b1, 1'b0, 1'b0, 32'd1);

    // Halt request coinciding with an accepted fetch: fetch counts, then halts.
    drive(1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1);
    @(posedge clk);
    #1;
    check("halt_with_accept", 32'h8, 1'b0, 1'b1, 1'b0, 32'd2);
    @(posedge clk);
    #1;
    check("halt_no_fetch", 32'h8, 1'b0, 1'b1, 1'b0, 32'd2);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
